// File: rtl/cipher_block_uart_tx_if.sv
// Block handshake bundle for cipher_block_uart_tx.
//   i_data        : cipher block, byte k = i_data[k*8 +: 8]
//   i_data_valid  : source offers a block, held until accepted
//   o_data_ready  : transmitter can take a block this cycle
// master = block source, slave = transmitter.
interface cipher_block_uart_tx_if #(
    parameter int N_BYTES = 16
);
    logic [N_BYTES*8-1:0] i_data;
    logic                 i_data_valid;
    logic                 o_data_ready;

    modport master (
        output i_data,
        output i_data_valid,
        input  o_data_ready
    );

    modport slave (
        input  i_data,
        input  i_data_valid,
        output o_data_ready
    );
endinterface

// File: rtl/cipher_block_uart_tx.sv
// Serialises one N_BYTES cipher block onto a UART line (8N1, idle high),
// byte 0 first, LSB first, with no idle gap between the bytes of a block.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   blk       : block handshake (i_data / i_data_valid / o_data_ready)
//   o_uart_tx : serial line, driven from a register
//   o_busy    : block transfer in progress
//   o_done    : one-cycle pulse on the final cycle of the last stop bit
module cipher_block_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int N_BYTES      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    cipher_block_uart_tx_if.slave  blk,
    output logic                   o_uart_tx,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [BAUD_W-1:0]    baud_cnt, baud_n;
    logic [2:0]           bit_cnt, bit_n;
    logic [IDX_W-1:0]     byte_idx, idx_n;
    logic [N_BYTES*8-1:0] shadow, shadow_n;
    logic                 tx_q, tx_n;
    logic [7:0]           cur_byte;
    logic                 baud_end;
    logic                 accept;

    function automatic logic [7:0] byte_of(input logic [N_BYTES*8-1:0] b,
                                           input logic [IDX_W-1:0] idx);
        byte_of = b[int'(idx)*8 +: 8];
    endfunction

    assign blk.o_data_ready = (state == IDLE) && !reset;
    assign accept           = blk.i_data_valid && blk.o_data_ready;
    assign baud_end         = (baud_cnt == BAUD_LAST);
    assign o_busy           = (state != IDLE);
    // Decoded from registered state so the pulse sits on the last stop-bit
    // cycle; a held valid is then taken on the very next (idle) cycle.
    assign o_done           = !reset && (state == STOP) && baud_end && (byte_idx == IDX_LAST);
    assign o_uart_tx        = tx_q;

    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        idx_n    = byte_idx;
        shadow_n = shadow;
        tx_n     = 1'b1;
        cur_byte = 8'h00;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n  = START;
                    baud_n   = '0;
                    bit_n    = '0;
                    idx_n    = '0;
                    shadow_n = blk.i_data;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_n   = '0;
                        state_n = STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (byte_idx == IDX_LAST) begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n   = byte_idx + 1'b1;
                        state_n = START;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is computed for the state being entered so that the
        // registered output lines up with the state it belongs to.
        cur_byte = byte_of(shadow_n, idx_n);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = cur_byte[bit_n];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            byte_idx <= idx_n;
            tx_q     <= tx_n;
        end
    end

    // Data shadow carries no reset; it is only observed after an accept.
    always_ff @(posedge clk) begin
        shadow <= shadow_n;
    end

endmodule

// File: tb/tb_cipher_block_uart_tx.sv
module tb_cipher_block_uart_tx;

    localparam int CPB  = 4;
    localparam int NB   = 16;
    localparam int BLKW = NB * 8;

    logic clk;
    logic reset;
    logic o_uart_tx;
    logic o_busy;
    logic o_done;

    cipher_block_uart_tx_if #(.N_BYTES(NB)) bif ();

    cipher_block_uart_tx #(.CLKS_PER_BIT(CPB), .N_BYTES(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .blk       (bif.slave),
        .o_uart_tx (o_uart_tx),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: expected line level per cycle, one entry per clock of the
    // transfer. Built from bytes and the frame rule (start 0, 8 LSB-first, stop 1).
    bit exp_q[$];

    task automatic push_block(input logic [BLKW-1:0] d);
        logic [7:0] b;
        bit frame[10];
        for (int k = 0; k < NB; k++) begin
            b = d[k*8 +: 8];
            frame[0] = 1'b0;
            for (int i = 0; i < 8; i++) frame[i+1] = b[i];
            frame[9] = 1'b1;
            for (int f = 0; f < 10; f++)
                for (int c = 0; c < CPB; c++) exp_q.push_back(frame[f]);
        end
    endtask

    always @(posedge clk) begin
        bit was_empty;
        was_empty = (exp_q.size() == 0);
        if (!was_empty) void'(exp_q.pop_front());
        if (reset) exp_q.delete();
        else if (bif.i_data_valid && was_empty) push_block(bif.i_data);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic etx, ebusy, eready, edone;
            etx    = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
            ebusy  = (exp_q.size() != 0);
            eready = !reset && (exp_q.size() == 0);
            edone  = !reset && (exp_q.size() == 1);
            check("tx",    32'(o_uart_tx),        32'(etx));
            check("busy",  32'(o_busy),           32'(ebusy));
            check("ready", 32'(bif.o_data_ready), 32'(eready));
            check("done",  32'(o_done),           32'(edone));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers d until accepted; returns at the start of the first start-bit cycle.
    task automatic send_block(input logic [BLKW-1:0] d);
        bit ok;
        ok = 1'b0;
        bif.i_data       = d;
        bif.i_data_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bif.o_data_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        step();
        bif.i_data_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n++;
            if (o_done === 1'b1) begin found = 1'b1; break; end
        end
        if (!found) check(name, 32'd0, 32'd1);
    endtask

    function automatic logic [BLKW-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [BLKW-1:0] d, d2;
        int n;
        bit exp_a5[10];
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        reset = 1'b1;
        bif.i_data = '0;
        bif.i_data_valid = 1'b0;
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_tx",    32'(o_uart_tx),        32'd1);
        check("rst_busy",  32'(o_busy),           32'd0);
        check("rst_ready", 32'(bif.o_data_ready), 32'd0);
        check("rst_done",  32'(o_done),           32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bif.o_data_ready), 32'd1);

        // Counting bytes 00..0F, done latency
        for (int k = 0; k < NB; k++) d[k*8 +: 8] = 8'(k);
        send_block(d);
        wait_done("done_timeout_count", n);
        check("done_latency", 32'(n), 32'd640);

        // All A5: literal frame pattern and no inter-frame gap
        step();
        for (int k = 0; k < NB; k++) d[k*8 +: 8] = 8'hA5;
        send_block(d);
        for (int j = 1; j <= 42; j++) begin
            @(negedge clk);
            if (j <= 40 && (j % 4) == 2) check("a5_bit", 32'(o_uart_tx), 32'(exp_a5[(j-2)/4]));
            if (j == 42) check("a5_no_gap", 32'(o_uart_tx), 32'd0);
        end
        wait_done("done_timeout_a5", n);

        // Back-to-back with valid held
        step();
        d  = rand_block();
        d2 = rand_block();
        bif.i_data = d;
        bif.i_data_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bif.o_data_ready === 1'b1) break;
        end
        step();
        bif.i_data = d2;
        wait_done("done_timeout_b2b1", n);
        check("b2b_done_tx", 32'(o_uart_tx), 32'd1);
        @(negedge clk);
        check("b2b_gap_tx",    32'(o_uart_tx),        32'd1);
        check("b2b_gap_ready", 32'(bif.o_data_ready), 32'd1);
        step();
        bif.i_data_valid = 1'b0;
        @(negedge clk);
        check("b2b_start_tx",   32'(o_uart_tx), 32'd0);
        check("b2b_start_busy", 32'(o_busy),    32'd1);
        wait_done("done_timeout_b2b2", n);

        // Valid pulsed while busy, data altered after accept
        step();
        send_block(rand_block());
        bif.i_data = rand_block();
        repeat (50) step();
        bif.i_data = rand_block();
        bif.i_data_valid = 1'b1;
        step();
        bif.i_data_valid = 1'b0;
        wait_done("done_timeout_ignore", n);
        repeat (20) @(negedge clk);
        check("ignore_idle_busy", 32'(o_busy), 32'd0);

        // Reset during byte 7 data bit 3
        step();
        send_block(rand_block());
        repeat (297) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("abort_tx",    32'(o_uart_tx),        32'd1);
        check("abort_busy",  32'(o_busy),           32'd0);
        check("abort_done",  32'(o_done),           32'd0);
        check("abort_ready", 32'(bif.o_data_ready), 32'd1);
        repeat (30) @(negedge clk);

        // Valid together with reset
        step();
        bif.i_data = rand_block();
        bif.i_data_valid = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bif.i_data_valid = 1'b0;
        @(negedge clk);
        check("vr_tx",    32'(o_uart_tx),        32'd1);
        check("vr_busy",  32'(o_busy),           32'd0);
        check("vr_ready", 32'(bif.o_data_ready), 32'd1);
        repeat (10) @(negedge clk);

        // Randomised blocks with stray valids and occasional aborts
        for (int r = 0; r < 6; r++) begin
            step();
            repeat ($urandom_range(0, 5)) step();
            send_block(rand_block());
            if (r % 2 == 1) begin
                repeat (30) step();
                bif.i_data = rand_block();
                bif.i_data_valid = 1'b1;
                step();
                bif.i_data_valid = 1'b0;
            end
            if (r % 3 == 2) begin
                repeat ($urandom_range(10, 500)) step();
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                reset = 1'b0;
                repeat (5) @(negedge clk);
            end else begin
                wait_done("done_timeout_rand", n);
            end
        end
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
